// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA output bundle of vga_frame_reader.
// master = the reader, slave = buffer/display side.
interface vga_frame_reader_if #(
   parameter int AW = 15,
   parameter int DW = 8
);
   logic [AW-1:0] addr_out;
   logic [DW-1:0] data_in;
   logic          vga_hsync;
   logic          vga_vsync;
   logic          vga_de;
   logic [3:0]    vga_r;
   logic [3:0]    vga_g;
   logic [3:0]    vga_b;
   logic          frame_start;

   modport master (
      output addr_out,
      input  data_in,
      output vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b, frame_start
   );

   modport slave (
      input  addr_out,
      output data_in,
      input  vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b, frame_start
   );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator that reads an RGB332 frame buffer, upscales it by 2**SCALE_SH
// and drives RGB444 with sync/de aligned to the pixel data (3-clk pipeline).
module vga_frame_reader #(
   parameter int AW       = 15,
   parameter int DW       = 8,
   parameter int IMG_W    = 160,
   parameter int IMG_H    = 120,
   parameter int SCALE_SH = 2,
   parameter int H_ACT    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACT    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic               clk,
   input  logic               rst,
   vga_frame_reader_if.master bus
);
   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   // Per-position attributes travelling alongside the buffer read; sync kept active-high
   // so a cleared stage means "not in sync" and the outputs stay idle after reset.
   typedef struct packed {
      logic hsa;
      logic vsa;
      logic de;
      logic img;
      logic fs;
   } tag_t;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [AW-1:0] addr_q, addr_d;
   tag_t          tag_d;
   tag_t [1:0]    tag_q;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          fs_q, fs_d;
   logic [11:0]   rgb_q, rgb_d;

   always_comb begin
      h_d = h_q + HW'(1);
      v_d = v_q;
      if (int'(h_q) == H_TOT - 1) begin
         h_d = '0;
         v_d = (int'(v_q) == V_TOT - 1) ? '0 : v_q + VW'(1);
      end

      tag_d.de  = (int'(h_q) < H_ACT) && (int'(v_q) < V_ACT);
      tag_d.img = tag_d.de && (int'(h_q) < (IMG_W << SCALE_SH))
                           && (int'(v_q) < (IMG_H << SCALE_SH));
      tag_d.hsa = (int'(h_q) >= H_ACT + H_FP) && (int'(h_q) < H_ACT + H_FP + H_SYNC);
      tag_d.vsa = (int'(v_q) >= V_ACT + V_FP) && (int'(v_q) < V_ACT + V_FP + V_SYNC);
      tag_d.fs  = (h_q == '0) && (v_q == '0);

      // Address only moves inside the image, so it can never leave 0..IMG_W*IMG_H-1.
      addr_d = addr_q;
      if (tag_d.img)
         addr_d = AW'((int'(v_q) >> SCALE_SH) * IMG_W + (int'(h_q) >> SCALE_SH));

      hsync_d = ~tag_q[1].hsa;
      vsync_d = ~tag_q[1].vsa;
      de_d    = tag_q[1].de;
      fs_d    = tag_q[1].fs;
      rgb_d   = '0;
      if (tag_q[1].img)
         rgb_d = {bus.data_in[7:5], bus.data_in[7],
                  bus.data_in[4:2], bus.data_in[4],
                  bus.data_in[1:0], bus.data_in[1:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q     <= '0;
         v_q     <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         rgb_q   <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         addr_q  <= addr_d;
         tag_q   <= {tag_q[0], tag_d};
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         rgb_q   <= rgb_d;
      end
   end

   assign bus.addr_out    = addr_q;
   assign bus.vga_hsync   = hsync_q;
   assign bus.vga_vsync   = vsync_q;
   assign bus.vga_de      = de_q;
   assign bus.frame_start = fs_q;
   assign bus.vga_r       = rgb_q[11:8];
   assign bus.vga_g       = rgb_q[7:4];
   assign bus.vga_b       = rgb_q[3:0];
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: full-size reader for addressing/colour/line timing, plus two
// reduced-timing readers for whole-frame counts, image clipping and mid-frame reset.
module tb_vga_frame_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #20 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int k    = 0;

   vga_frame_reader_if #(.AW(15), .DW(8)) ba ();
   vga_frame_reader_if #(.AW(15), .DW(8)) bs ();
   vga_frame_reader_if #(.AW(15), .DW(8)) bt ();

   vga_frame_reader u_a (.clk(clk), .rst(rst), .bus(ba.master));

   vga_frame_reader #(
      .IMG_W(4), .IMG_H(3), .SCALE_SH(2),
      .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACT(12), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_s (.clk(clk), .rst(rst), .bus(bs.master));

   vga_frame_reader #(
      .IMG_W(3), .IMG_H(2), .SCALE_SH(2),
      .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACT(12), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_t (.clk(clk), .rst(rst), .bus(bt.master));

   function automatic logic [7:0] ram_a(input logic [14:0] a);
      case (a)
         15'd0:   return 8'hE0;
         15'd1:   return 8'h1C;
         15'd2:   return 8'h03;
         default: return a[7:0];
      endcase
   endfunction

   // Buffer models, 1-clk read latency
   always_ff @(posedge clk) begin
      ba.data_in <= ram_a(ba.addr_out);
      bs.data_in <= bs.addr_out[7:0];
      bt.data_in <= 8'hFF;
   end

   wire [11:0] a_rgb = {ba.vga_r, ba.vga_g, ba.vga_b};
   wire [11:0] s_rgb = {bs.vga_r, bs.vga_g, bs.vga_b};
   wire [11:0] t_rgb = {bt.vga_r, bt.vga_g, bt.vga_b};

   // Two-frame statistics of the small reader
   logic cnt_on = 1'b0;
   int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
   int   fs_k0 = 0, fs_k1 = 0;
   int   tmax = 0;

   always @(negedge clk) begin
      if (cnt_on) begin
         if (bs.vga_de)     de_cnt++;
         if (!bs.vga_hsync) hs_cnt++;
         if (!bs.vga_vsync) vs_cnt++;
         if (bs.frame_start) begin
            if (fs_cnt == 0) fs_k0 = k;
            else             fs_k1 = k;
            fs_cnt++;
         end
      end
      if (!rst && int'(bt.addr_out) > tmax) tmax = int'(bt.addr_out);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic adv_to(input int kk);
      while (k < kk) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hsync", 32'(ba.vga_hsync), 32'd1);
      chk("rst_vsync", 32'(ba.vga_vsync), 32'd1);
      chk("rst_de",    32'(ba.vga_de), 32'd0);
      chk("rst_rgb",   32'(a_rgb), 32'h000);
      chk("rst_fs",    32'(ba.frame_start), 32'd0);
      chk("rst_addr",  32'(ba.addr_out), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b0;
      k   = 0;

      adv_to(1);  chk("addr_h0", 32'(ba.addr_out), 32'd0);
      adv_to(2);  chk("de_k2", 32'(ba.vga_de), 32'd0);
                  chk("addr_h1", 32'(ba.addr_out), 32'd0);
      adv_to(3);  chk("de_k3", 32'(ba.vga_de), 32'd1);
                  chk("fs_k3", 32'(ba.frame_start), 32'd1);
                  chk("px0", 32'(a_rgb), 32'hF00);
                  chk("s_de_k3", 32'(bs.vga_de), 32'd1);
                  chk("s_fs_k3", 32'(bs.frame_start), 32'd1);
                  cnt_on = 1'b1;
      adv_to(4);  chk("fs_k4", 32'(ba.frame_start), 32'd0);
                  chk("addr_h3", 32'(ba.addr_out), 32'd0);
      adv_to(5);  chk("addr_h4", 32'(ba.addr_out), 32'd1);
      adv_to(6);  chk("px3", 32'(a_rgb), 32'hF00);
      adv_to(7);  chk("px4", 32'(a_rgb), 32'h0F0);
      adv_to(10); chk("px7", 32'(a_rgb), 32'h0F0);
      adv_to(11); chk("px8", 32'(a_rgb), 32'h00F);
      adv_to(14); chk("px11", 32'(a_rgb), 32'h00F);
      adv_to(15); chk("t_out_h_de", 32'(bt.vga_de), 32'd1);
                  chk("t_out_h_rgb", 32'(t_rgb), 32'h000);
      adv_to(19); chk("px16", 32'(a_rgb), 32'h020);
      adv_to(23); chk("px20", 32'(a_rgb), 32'h025);
      adv_to(182); chk("t_in_rgb", 32'(t_rgb), 32'hFFF);
      adv_to(195); chk("t_out_v_de", 32'(bt.vga_de), 32'd1);
                   chk("t_out_v_rgb", 32'(t_rgb), 32'h000);
      adv_to(280); chk("s_addr_last", 32'(bs.addr_out), 32'd11);
      adv_to(281); chk("s_addr_hold", 32'(bs.addr_out), 32'd11);
      adv_to(642); chk("px639_de", 32'(ba.vga_de), 32'd1);
                   chk("px639", 32'(a_rgb), 32'h9FF);
      adv_to(643); chk("px640_de", 32'(ba.vga_de), 32'd0);
                   chk("px640_rgb", 32'(a_rgb), 32'h000);
      adv_to(658); chk("hs_655", 32'(ba.vga_hsync), 32'd1);
      adv_to(659); chk("hs_656", 32'(ba.vga_hsync), 32'd0);
      adv_to(754); chk("hs_751", 32'(ba.vga_hsync), 32'd0);
      adv_to(755); chk("hs_752", 32'(ba.vga_hsync), 32'd1);
      adv_to(771);
      cnt_on = 1'b0;
      chk("s_de_count", 32'(de_cnt), 32'd384);
      chk("s_hs_count", 32'(hs_cnt), 32'd128);
      chk("s_vs_count", 32'(vs_cnt), 32'd96);
      chk("s_fs_count", 32'(fs_cnt), 32'd2);
      chk("s_fs_period", 32'(fs_k1 - fs_k0), 32'd384);
      adv_to(803);  chk("line1_px0", 32'(a_rgb), 32'hF00);
      adv_to(3201); chk("addr_v4", 32'(ba.addr_out), 32'd160);
      adv_to(3203); chk("px_v4", 32'(a_rgb), 32'hB00);

      // Mid-frame reset with the small reader at h=5, v=6
      adv_to(3605);
      chk("t_addr_max", 32'(tmax), 32'd5);
      chk("s_de_pre", 32'(bs.vga_de), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_s_de", 32'(bs.vga_de), 32'd0);
      chk("mrst_s_rgb", 32'(s_rgb), 32'h000);
      chk("mrst_s_hs", 32'(bs.vga_hsync), 32'd1);
      chk("mrst_a_de", 32'(ba.vga_de), 32'd0);
      chk("mrst_a_addr", 32'(ba.addr_out), 32'd0);
      rst = 1'b0;
      k   = 0;
      adv_to(2); chk("mrst_s_fs_k2", 32'(bs.frame_start), 32'd0);
      adv_to(3); chk("mrst_s_fs_k3", 32'(bs.frame_start), 32'd1);
                 chk("mrst_a_fs_k3", 32'(ba.frame_start), 32'd1);
                 chk("mrst_s_de_k3", 32'(bs.vga_de), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
